mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-port (fetch/data) memory request arbiter with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_req_arbiter #(
  parameter int DW         = 33,
  parameter int OUTSTD_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          s_req,
  input  logic [1:0]          s_we,
  input  logic [1:0][3:0]     s_be,
  input  logic [1:0][31:0]    s_addr,
  input  logic [1:0][DW-1:0]  s_wdata,
  output logic [1:0]          s_gnt,
  output logic [1:0]          s_rvalid,
  output logic [1:0]          s_err,
  output logic [1:0][DW-1:0]  s_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [3:0]          m_be,
  output logic [31:0]         m_addr,
  output logic [DW-1:0]       m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic                m_err,
  input  logic [DW-1:0]       m_rdata,
  output logic                unexp_rsp
);

  localparam int PW = (OUTSTD_MAX > 1) ? $clog2(OUTSTD_MAX) : 1;
  localparam int CW = $clog2(OUTSTD_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                state, state_nxt;
  logic                  sel, arb_sel;
  logic                  full, empty, push, pop, head;
  logic [OUTSTD_MAX-1:0] fifo_q;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

`ifdef MEM_ARB_RR_EN
  logic rr_pref;

  // Port just granted loses preference for the next contested arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_pref <= 1'b0;
    else if (push) rr_pref <= ~sel;
  end

  assign arb_sel = (s_req[0] && s_req[1]) ? rr_pref : s_req[1];
`else
  assign arb_sel = s_req[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_req && !m_gnt) state_nxt = sel ? LOCK1 : LOCK0;
      LOCK0:   if (!s_req[0] || push) state_nxt = IDLE;
      LOCK1:   if (!s_req[1] || push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      LOCK0:   sel = 1'b0;
      LOCK1:   sel = 1'b1;
      default: sel = arb_sel;
    endcase
    // s_req is ignored while reset is held so every output reads zero.
    m_req   = rst_n && s_req[sel] && !full;
    m_we    = rst_n && s_we[sel];
    m_be    = rst_n ? s_be[sel]    : '0;
    m_addr  = rst_n ? s_addr[sel]  : '0;
    m_wdata = rst_n ? s_wdata[sel] : '0;
    push    = m_req && m_gnt;
    s_gnt   = '0;
    s_gnt[sel] = push;
  end

  assign full  = (count == CW'(OUTSTD_MAX));
  assign empty = (count == '0);
  assign pop   = m_rvalid && !empty;
  assign head  = fifo_q[rd_ptr];

  always_comb begin
    s_rvalid = '0;
    s_err    = '0;
    s_rdata  = '0;
    if (pop) begin
      s_rvalid[head] = 1'b1;
      s_err[head]    = m_err;
      s_rdata[head]  = m_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= sel;
        wr_ptr <= (wr_ptr == PW'(OUTSTD_MAX - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(OUTSTD_MAX - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 unexp_rsp <= 1'b0;
    else if (m_rvalid && empty) unexp_rsp <= 1'b1;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (default parameters).
module tb_mem_req_arbiter;
  localparam int DW = 33;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         s_req, s_we;
  logic [1:0][3:0]    s_be;
  logic [1:0][31:0]   s_addr;
  logic [1:0][DW-1:0] s_wdata;
  logic [1:0]         s_gnt, s_rvalid, s_err;
  logic [1:0][DW-1:0] s_rdata;
  logic               m_req, m_we;
  logic [3:0]         m_be;
  logic [31:0]        m_addr;
  logic [DW-1:0]      m_wdata;
  logic               m_gnt, m_rvalid, m_err;
  logic [DW-1:0]      m_rdata;
  logic               unexp_rsp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.DW(DW), .OUTSTD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
    .unexp_rsp(unexp_rsp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_req = 2'b11; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 33'h1_5555_5555;
    #3;
    n_checks++;
    if ({m_req, m_we, m_be, m_addr, m_wdata} !== '0)
      $display("FAIL reset_m_side: got req=%b we=%b be=%h addr=%h wdata=%h, need all 0", m_req, m_we, m_be, m_addr, m_wdata);
    else n_pass++;
    n_checks++;
    if ({s_gnt, s_rvalid, s_err} !== 6'b0)
      $display("FAIL reset_s_side: got gnt=%b rvalid=%b err=%b, need 0", s_gnt, s_rvalid, s_err);
    else n_pass++;
    n_checks++;
    if (s_rdata !== '0) $display("FAIL reset_rdata: got %h, need 0", s_rdata);
    else n_pass++;
    n_checks++;
    if (unexp_rsp !== 1'b0) $display("FAIL reset_unexp: got %b, need 0", unexp_rsp);
    else n_pass++;
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (m_req !== 1'b0 || unexp_rsp !== 1'b0)
      $display("FAIL post_reset_idle: got m_req=%b unexp=%b, need 0 0", m_req, unexp_rsp);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_g [4];
`ifdef MEM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    for (int i = 0; i < 4; i++) begin
      s_req = 2'b11; m_gnt = 1'b1;
      #1;
      n_checks++;
      if (s_gnt !== exp_g[i] || m_addr !== (exp_g[i][1] ? A1 : A0))
        $display("FAIL arb_grant_%0d: got gnt=%b addr=%h, need gnt=%b addr=%h", i, s_gnt, m_addr, exp_g[i], exp_g[i][1] ? A1 : A0);
      else n_pass++;
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rdata = DW'(i + 1);
      #1;
      n_checks++;
      if (s_rvalid !== exp_g[i] || s_rdata[exp_g[i][1]] !== DW'(i + 1))
        $display("FAIL arb_rsp_%0d: got rvalid=%b rdata=%h, need rvalid=%b rdata=%h", i, s_rvalid, s_rdata[exp_g[i][1]], exp_g[i], i + 1);
      else n_pass++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    s_req = 2'b01; m_gnt = 1'b0;
    #1;
    n_checks++;
    if (m_req !== 1'b1 || s_gnt !== 2'b00) $display("FAIL lock_c0: got m_req=%b gnt=%b, need 1 00", m_req, s_gnt);
    else n_pass++;
    step();
    for (int c = 1; c < 3; c++) begin
      s_req = 2'b11;
      #1;
      n_checks++;
      if (s_gnt !== 2'b00 || m_addr !== A0) $display("FAIL lock_c%0d: got gnt=%b addr=%h, need 00 %h", c, s_gnt, m_addr, A0);
      else n_pass++;
      step();
    end
    m_gnt = 1'b1;
    #1;
    n_checks++;
    if (s_gnt !== 2'b01) $display("FAIL lock_c3_grant: got gnt=%b, need 01", s_gnt);
    else n_pass++;
    step();
    idle_inputs();
    m_rvalid = 1'b1; m_rdata = 33'h0_0000_0077;
    #1;
    n_checks++;
    if (s_rvalid !== 2'b01 || s_rdata[0] !== 33'h0_0000_0077) $display("FAIL lock_rsp: got rvalid=%b rdata0=%h, need 01 77", s_rvalid, s_rdata[0]);
    else n_pass++;
    step();
    idle_inputs();
    // Requester abandons a locked request: the lock releases without a grant.
    s_req = 2'b01;
    step();
    s_req = 2'b10;
    #1;
    n_checks++;
    if (m_req !== 1'b0 || s_gnt !== 2'b00) $display("FAIL lock_drop_held: got m_req=%b gnt=%b, need 0 00", m_req, s_gnt);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (m_req !== 1'b1 || m_addr !== A1) $display("FAIL lock_drop_release: got m_req=%b addr=%h, need 1 %h", m_req, m_addr, A1);
    else n_pass++;
    s_req = 2'b00;
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      s_req = 2'b01; m_gnt = 1'b1;
      #1;
      n_checks++;
      if (s_gnt !== 2'b01) $display("FAIL full_fill_%0d: got gnt=%b, need 01", i, s_gnt);
      else n_pass++;
      step();
    end
    #1;
    n_checks++;
    if (m_req !== 1'b0 || s_gnt !== 2'b00) $display("FAIL full_block: got m_req=%b gnt=%b, need 0 00", m_req, s_gnt);
    else n_pass++;
    step();
    m_rvalid = 1'b1; m_rdata = 33'h0_0000_0100;
    #1;
    n_checks++;
    if (m_req !== 1'b0 || s_gnt !== 2'b00 || s_rvalid !== 2'b01)
      $display("FAIL full_pop_same: got m_req=%b gnt=%b rvalid=%b, need 0 00 01", m_req, s_gnt, s_rvalid);
    else n_pass++;
    step();
    m_rvalid = 1'b0;
    #1;
    n_checks++;
    if (m_req !== 1'b1 || s_gnt !== 2'b01) $display("FAIL full_reassert: got m_req=%b gnt=%b, need 1 01", m_req, s_gnt);
    else n_pass++;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1;
      #1;
      n_checks++;
      if (s_rvalid !== 2'b01) $display("FAIL full_drain_%0d: got rvalid=%b, need 01", i, s_rvalid);
      else n_pass++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_order();
    logic            port [4];
    logic [DW-1:0]   data [4];
    port = '{1'b0, 1'b1, 1'b1, 1'b0};
    data = '{33'hA, 33'hB, 33'hC, 33'hD};
    for (int i = 0; i < 4; i++) begin
      s_req = port[i] ? 2'b10 : 2'b01; m_gnt = 1'b1;
      #1;
      n_checks++;
      if (s_gnt !== s_req) $display("FAIL order_grant_%0d: got gnt=%b, need %b", i, s_gnt, s_req);
      else n_pass++;
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_v;
      exp_v = port[i] ? 2'b10 : 2'b01;
      m_rvalid = 1'b1; m_rdata = data[i]; m_err = (i == 2);
      #1;
      n_checks++;
      if (s_rvalid !== exp_v || s_rdata[port[i]] !== data[i] || s_rdata[~port[i]] !== '0 || s_err !== ((i == 2) ? exp_v : 2'b00))
        $display("FAIL order_rsp_%0d: got rvalid=%b err=%b rdata1=%h rdata0=%h, need rvalid=%b data=%h", i, s_rvalid, s_err, s_rdata[1], s_rdata[0], exp_v, data[i]);
      else n_pass++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_unexpected();
    m_rvalid = 1'b1; m_rdata = 33'h1_0000_00EE;
    #1;
    n_checks++;
    if (s_rvalid !== 2'b00 || unexp_rsp !== 1'b0) $display("FAIL unexp_nofwd: got rvalid=%b unexp=%b, need 00 0", s_rvalid, unexp_rsp);
    else n_pass++;
    step();
    idle_inputs();
    step();
    step();
    n_checks++;
    if (unexp_rsp !== 1'b1) $display("FAIL unexp_sticky: got %b, need 1", unexp_rsp);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (unexp_rsp !== 1'b0) $display("FAIL unexp_clear: got %b, need 0", unexp_rsp);
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      s_req = 2'b11; m_gnt = 1'b1;
      step();
    end
    m_gnt = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    m_rvalid = 1'b1;
    #1;
    n_checks++;
    if (m_req !== 1'b0 || s_gnt !== 2'b00 || s_rvalid !== 2'b00 || m_addr !== '0 || unexp_rsp !== 1'b0)
      $display("FAIL midrst_outputs: got m_req=%b gnt=%b rvalid=%b addr=%h unexp=%b, need all 0", m_req, s_gnt, s_rvalid, m_addr, unexp_rsp);
    else n_pass++;
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
    m_rvalid = 1'b1;
    #1;
    n_checks++;
    if (s_rvalid !== 2'b00) $display("FAIL midrst_dropped: got rvalid=%b, need 00", s_rvalid);
    else n_pass++;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (unexp_rsp !== 1'b1) $display("FAIL midrst_unexp: got %b, need 1", unexp_rsp);
    else n_pass++;
    s_req = 2'b01;
    #1;
    n_checks++;
    if (m_req !== 1'b1 || m_addr !== A0) $display("FAIL midrst_idle: got m_req=%b addr=%h, need 1 %h", m_req, m_addr, A0);
    else n_pass++;
    s_req = 2'b00;
    step();
  endtask

  initial begin
    s_we = 2'b10;
    s_be[0] = 4'hF; s_be[1] = 4'h3;
    s_addr[0] = A0; s_addr[1] = A1;
    s_wdata[0] = 33'h0_1111_1111; s_wdata[1] = 33'h1_2222_2222;
    idle_inputs();
    test_reset();
    test_arbitration();
    test_lock();
    test_full();
    test_order();
    test_unexpected();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
